// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the FSM state encodings
// that lite slaves in this codebase have in common.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_inf.sv
// AXI-Lite bundle carrying the aw/w/b/ar/r channels, with master and slave
// views.
interface axi_lite_inf #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32
);

  logic [ASIZE-1:0]   awaddr;
  logic               awvalid;
  logic               awready;
  logic [DSIZE-1:0]   wdata;
  logic [DSIZE/8-1:0] wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [ASIZE-1:0]   araddr;
  logic               arvalid;
  logic               arready;
  logic [DSIZE-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module axi_lite_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_slave_default_resp.sv
// Default AXI-Lite slave: absorbs every transaction with a fixed response and
// fixed read data, and records counts plus the last accepted address.
module axi_lite_slave_default_resp
  import axi_lite_pkg::*;
#(
  parameter logic [1:0]  RESP          = RESP_DECERR,
  parameter logic [31:0] RDATA_PATTERN = 32'hDEAD_BEEF,
  parameter int          CNT_W         = 16,
  parameter int          ASIZE         = 32,
  parameter int          DSIZE         = 32
) (
  input  logic             clock,
  input  logic             rst,
  axi_lite_inf.slave       lite,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic [ASIZE-1:0] last_addr,
  output logic             last_is_wr
);

  // Pattern widened with zeros first so narrow and wide buses both just slice.
  localparam logic [DSIZE+31:0] RDATA_EXT = {{DSIZE{1'b0}}, RDATA_PATTERN};
  localparam logic [DSIZE-1:0]  RDATA_FIT = RDATA_EXT[DSIZE-1:0];

  wr_state_t wr_state;
  rd_state_t rd_state;
  logic      aw_got, w_got;
  logic      awready_r, wready_r, bvalid_r;
  logic      arready_r, rvalid_r;
  logic      aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic      aw_done, w_done;
  logic      unused_wr_payload;

  assign aw_hs   = lite.awvalid & awready_r;
  assign w_hs    = lite.wvalid & wready_r;
  assign ar_hs   = lite.arvalid & arready_r;
  assign b_hs    = bvalid_r & lite.bready;
  assign r_hs    = rvalid_r & lite.rready;
  assign aw_done = aw_got | aw_hs;
  assign w_done  = w_got | w_hs;

  assign lite.awready = awready_r;
  assign lite.wready  = wready_r;
  assign lite.bvalid  = bvalid_r;
  assign lite.bresp   = RESP;
  assign lite.arready = arready_r;
  assign lite.rvalid  = rvalid_r;
  assign lite.rresp   = RESP;
  assign lite.rdata   = RDATA_FIT;

  assign unused_wr_payload = ^{lite.wdata, lite.wstrb};

  // Write path: collect AW and W in any order, then one B beat.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_state  <= W_COLLECT;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      awready_r <= 1'b1;
      wready_r  <= 1'b1;
      bvalid_r  <= 1'b0;
    end else begin
      case (wr_state)
        W_COLLECT: begin
          if (aw_hs) aw_got <= 1'b1;
          if (w_hs)  w_got  <= 1'b1;
          if (aw_done && w_done) begin
            wr_state  <= W_RESP;
            bvalid_r  <= 1'b1;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
          end else begin
            awready_r <= ~aw_done;
            wready_r  <= ~w_done;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            wr_state  <= W_COLLECT;
            bvalid_r  <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        default: wr_state <= W_COLLECT;
      endcase
    end
  end

  // Read path: one AR accepted, then R held until taken.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state  <= R_DATA;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            rd_state  <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // AW wins over AR for the status capture when both are accepted together.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      last_addr  <= '0;
      last_is_wr <= 1'b0;
    end else if (aw_hs) begin
      last_addr  <= lite.awaddr;
      last_is_wr <= 1'b1;
    end else if (ar_hs) begin
      last_addr  <= lite.araddr;
      last_is_wr <= 1'b0;
    end
  end

  axi_lite_sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clock (clock),
    .rst   (rst),
    .en    (b_hs),
    .count (wr_count)
  );

  axi_lite_sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clock (clock),
    .rst   (rst),
    .en    (r_hs),
    .count (rd_count)
  );

endmodule

// File: doc/axi_lite_slave_default_resp.md
Name: axi_lite_slave_default_resp

Overview:
- AXI-Lite default slave: terminates any AXI-Lite master cleanly, returns a fixed response code and fixed read data, never stalls a master indefinitely.
- Sits behind interconnect decode holes or unpopulated address windows.
- Counts absorbed transactions and captures the last offending address for debug/status registers.
- Write and read paths are independent; AW and W are accepted in either order.

Parameters:
- RESP, 2'b11, response code driven on bresp/rresp (DECERR default; 2'b00 gives a silent OKAY sink).
- RDATA_PATTERN, 32'hDEAD_BEEF, read data returned, truncated/zero-extended to lite DSIZE.
- CNT_W, 16, width of transaction counters.

Ports:
- clock  input  1  block clock; same domain as lite interface clock.
- rst  input  1  asynchronous, active-high reset.
- lite  axi_lite_inf.slave  -  AXI-Lite slave port (aw/w/b/ar/r channels, ASIZE/DSIZE from interface).
- wr_count  output  CNT_W  completed write transactions (B handshakes), saturating.
- rd_count  output  CNT_W  completed read transactions (R handshakes), saturating.
- last_addr  output  ASIZE  address of most recently accepted AW or AR.
- last_is_wr  output  1  1 if last_addr came from AW, 0 if from AR.

Behaviour:
- Reset: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=RESP, rresp=RESP, rdata=RDATA_PATTERN, counters=0, last_addr=0, last_is_wr=0. Asserting rst mid-transaction drops bvalid/rvalid immediately; the in-flight transaction is lost and not counted.
- Write FSM states: W_COLLECT, W_RESP.
  - W_COLLECT: awready=!aw_got, wready=!w_got. AW handshake sets aw_got, captures awaddr to last_addr, sets last_is_wr=1. W handshake sets w_got; wdata/wstrb are discarded. Both handshakes may occur in the same cycle.
  - When aw_got&w_got (registered), or both handshakes complete in the current cycle, go to W_RESP. bvalid=1 on the next cycle, i.e. minimum 1 cycle after the final handshake. awready=wready=0 in W_RESP.
  - W_RESP: hold bvalid and bresp stable until bready. On bvalid&bready: wr_count++, clear aw_got/w_got, return to W_COLLECT. awready/wready re-assert the following cycle, giving one outstanding write.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready: capture araddr to last_addr, last_is_wr=0, go to R_DATA. rvalid=1 the next cycle, arready=0.
  - R_DATA: rvalid, rdata and rresp are stable until rready. On handshake: rd_count++, return to R_IDLE.
- Simultaneous AW and AR acceptance in the same cycle: last_addr takes the AW address and last_is_wr=1 (write priority for status only; both transactions proceed).
- Counters saturate at all-ones, with no wrap.
- Pre-asserted bready/rready are legal; response completes in the first valid cycle.
- No combinational path from any valid input to any ready output; all readies are registered.

Decomposition:
- Shared AXI-Lite package holds the response code constants RESP_OKAY/EXOKAY/SLVERR/DECERR and the write/read FSM state enums, so other lite slaves reuse them.
- Natural sub-module: axi_lite_sat_counter (saturating counter with enable), instantiated twice.
- Write and read FSMs stay in this module.

Test Plan:
- Write, AW before W by 3 cycles, bready=1 -> bvalid 1 cycle after W handshake, bresp=2'b11, wr_count=1, last_addr=AW addr, last_is_wr=1.
- Write, W before AW, and AW+W in the same cycle -> both complete, awready/wready low during W_RESP, wr_count=2.
- Read 0x40 with rready held low 5 cycles -> rvalid stable, rdata=32'hDEAD_BEEF, rresp=2'b11, arready=0 until the handshake, rd_count=1.
- Concurrent AW/W to 0x10 and AR to 0x20 in the same cycle -> both responses issued, last_addr=0x10, last_is_wr=1.
- CNT_W=2, 5 reads -> rd_count saturates at 3.
- rst pulsed while bvalid=1 -> bvalid=0 asynchronously, readies=1, counters=0; next write completes normally.
